alu_arbiter: RTL and testbench

- Shares the single 16-bit combinational ALU between two requesters: requester 0 is the execute stage and requester 1 is the address-generation/debug port.
- Arbitrates round-robin and registers the granted operands into the ALU inputs.
- Captures the ALU result and flags into a response register with valid/ready handshake.
- Maintains the architectural flag register (Z, V, N), updated only by requester-0 operations.

---
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (0)
// and the address-generation/debug port (1); owns the response register and flags_q.
module alu_arbiter #(
  parameter int unsigned DW  = 16,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_result,
  input  logic [2:0]     alu_flags,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_result,
  output logic [2:0]     rsp_flags,
  output logic [2:0]     flags_q
);

  localparam int unsigned FW    = 3;
  localparam int unsigned Z_BIT = 2;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_XOR = OPW'(2);
  localparam logic [OPW-1:0] OP_SLL = OPW'(4);
  localparam logic [OPW-1:0] OP_SRA = OPW'(5);
  localparam logic [OPW-1:0] OP_ROR = OPW'(6);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_d;
  logic   last_grant;
  logic   grant_id;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and grant; a tie goes to the requester that did not win last
  always_comb begin
    state_d    = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_grant)) req0_ready = 1'b1;
        else if (req1_valid)                           req1_ready = 1'b1;
        if (req0_valid || req1_valid) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else if (req0_ready) begin
      alu_op     <= req0_op;
      alu_a      <= req0_a;
      alu_b      <= req0_b;
      grant_id   <= 1'b0;
      last_grant <= 1'b0;
    end else if (req1_ready) begin
      alu_op     <= req1_op;
      alu_a      <= req1_a;
      alu_b      <= req1_b;
      grant_id   <= 1'b1;
      last_grant <= 1'b1;
    end
  end

  // Response capture and architectural flags (execute-stage results only)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      flags_q    <= '0;
    end else if (state == EXEC) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant_id;
      rsp_result <= alu_result;
      rsp_flags  <= alu_flags;
      if (!grant_id) begin
        case (alu_op)
          OP_ADD, OP_SUB:                 flags_q <= FW'(alu_flags);
          OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_q[Z_BIT] <= alu_flags[Z_BIT];
          default: ;
        endcase
      end
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a small ALU stub closes the loop from alu_* back
// to alu_result/alu_flags, and all expected values are hand-computed constants.
module tb_alu_arbiter;

  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_a, req0_b;
  logic           req1_valid, req1_ready;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_a, req1_b;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a, alu_b;
  logic [DW-1:0]  alu_result;
  logic [2:0]     alu_flags;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0]  rsp_result;
  logic [2:0]     rsp_flags, flags_q;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  // ALU stub: saturating add/sub, logic ops, shifts; 1000 is subtract-with-borrow
  always_comb begin
    logic signed [16:0] s;
    logic               v;
    logic [15:0]        r;
    s = '0;
    v = 1'b0;
    r = alu_a;
    case (alu_op)
      4'b0000: begin
        s = 17'($signed(alu_a)) + 17'($signed(alu_b));
        v = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]);
        r = v ? (alu_a[15] ? 16'h8000 : 16'h7FFF) : s[15:0];
      end
      4'b0001: begin
        s = 17'($signed(alu_a)) - 17'($signed(alu_b));
        v = (alu_a[15] != alu_b[15]) && (s[15] != alu_a[15]);
        r = v ? (alu_a[15] ? 16'h8000 : 16'h7FFF) : s[15:0];
      end
      4'b0010: r = alu_a ^ alu_b;
      4'b0011: r = alu_a & alu_b;
      4'b0100: r = alu_a << alu_b[3:0];
      4'b0101: r = 16'($signed(alu_a) >>> alu_b[3:0]);
      4'b0110: r = (alu_a >> alu_b[3:0]) | (alu_a << (5'd16 - 5'(alu_b[3:0])));
      4'b0111: r = alu_a | alu_b;
      4'b1000: r = alu_a - alu_b - 16'd1;
      default: r = alu_a;
    endcase
    alu_result = r;
    alu_flags  = {r == 16'h0000, v, r[15]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, confirm its ready pulse mid-cycle, drop it after the accept edge
  task automatic issue(input bit id, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    if (!id) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    @(negedge clk);
    chk(id ? "req1_ready_grant" : "req0_ready_grant", 32'(id ? req1_ready : req0_ready), 32'd1);
    step();
    if (!id) req0_valid = 1'b0;
    else     req1_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input bit id, input logic [15:0] res,
                           input logic [2:0] fl, input logic [2:0] fq);
    chk({tag, ".rsp_valid"},  32'(rsp_valid),  32'd1);
    chk({tag, ".rsp_id"},     32'(rsp_id),     32'(id));
    chk({tag, ".rsp_result"}, 32'(rsp_result), 32'(res));
    chk({tag, ".rsp_flags"},  32'(rsp_flags),  32'(fl));
    chk({tag, ".flags_q"},    32'(flags_q),    32'(fq));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b1;
    do_reset();

    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.alu_a",     32'(alu_a),     32'd0);
    chk("reset.flags_q",   32'(flags_q),   32'd0);
    @(negedge clk);
    chk("reset.ready_idle", 32'({req0_ready, req1_ready}), 32'd0);
    step();

    // 1: single ADD, latency accept N -> alu_* N+1 -> rsp_valid N+2
    issue(0, 4'b0000, 16'h1234, 16'h4321);
    chk("add.alu_op",    32'(alu_op),    32'h0);
    chk("add.alu_a",     32'(alu_a),     32'h1234);
    chk("add.alu_b",     32'(alu_b),     32'h4321);
    chk("add.rsp_early", 32'(rsp_valid), 32'd0);
    step();
    check_rsp("add", 0, 16'h5555, 3'b000, 3'b000);
    step();
    chk("add.rsp_drop", 32'(rsp_valid),  32'd0);
    chk("add.rsp_hold", 32'(rsp_result), 32'h5555);

    // 2: saturating ADD sets V; XOR to zero updates only Z
    issue(0, 4'b0000, 16'h7FFF, 16'h0123);
    step();
    check_rsp("sat", 0, 16'h7FFF, 3'b010, 3'b010);
    step();
    issue(0, 4'b0010, 16'hFAB3, 16'hFAB3);
    step();
    check_rsp("xor", 0, 16'h0000, 3'b100, 3'b110);
    step();

    // 3: contention from reset; req0 wins first, req1 is held and served next
    do_reset();
    req1_valid = 1'b1; req1_op = 4'b1000; req1_a = 16'hAB77; req1_b = 16'h0050;
    issue(0, 4'b0000, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("cont.req1_exec", 32'(req1_ready), 32'd0);
    step();
    check_rsp("cont0", 0, 16'h0000, 3'b100, 3'b100);
    @(negedge clk);
    chk("cont.req1_resp", 32'(req1_ready), 32'd0);
    step();
    issue(1, 4'b1000, 16'hAB77, 16'h0050);
    step();
    check_rsp("cont1", 1, 16'hAB26, 3'b001, 3'b100);
    step();

    // 4: backpressure with both pending; req0 wins (last grant was 1)
    rsp_ready  = 1'b0;
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 16'h00FF; req1_b = 16'h0F0F;
    issue(0, 4'b0001, 16'h0003, 16'h0010);
    step();
    for (int i = 0; i < 5; i++) begin
      check_rsp("bp", 0, 16'hFFF3, 3'b001, 3'b001);
      @(negedge clk);
      chk("bp.req1_ready", 32'(req1_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.req1_handshake", 32'(req1_ready), 32'd0);
    step();
    issue(1, 4'b0010, 16'h00FF, 16'h0F0F);
    step();
    check_rsp("bp1", 1, 16'h0FF0, 3'b000, 3'b001);
    step();

    // 5: reset while in EXEC discards the operation and clears flags_q
    issue(0, 4'b0000, 16'h0000, 16'h0000);
    rst = 1'b1;
    #1;
    chk("rstx.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstx.flags_q",   32'(flags_q),   32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstx.no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    issue(0, 4'b0000, 16'h8000, 16'h0001);
    step();
    check_rsp("fresh", 0, 16'h8001, 3'b001, 3'b001);
    step();

    // 6: requester 1 and non-flag opcodes leave flags_q alone; SLL updates Z only
    issue(1, 4'b0001, 16'h0000, 16'h0000);
    step();
    check_rsp("mask1", 1, 16'h0000, 3'b100, 3'b001);
    step();
    issue(0, 4'b0111, 16'h0000, 16'h0000);
    step();
    check_rsp("or", 0, 16'h0000, 3'b100, 3'b001);
    step();
    issue(0, 4'b0100, 16'h8000, 16'h0001);
    step();
    check_rsp("sll", 0, 16'h0000, 3'b100, 3'b101);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
